decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Decodes one instruction per cycle into a

---
 rtl/decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute, with valid/ready on both sides
// and a per-register pending-write scoreboard that holds issue on RAW and counter-saturation hazards.
// Optional feature macro: DECODE_STAGE_RV32M_EN (adds M-extension OP decode and the o_mdu port).
module decode_stage #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_flush,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [31:0]     o_immediate,
    output logic [4:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [4:0]      o_rsa,
    output logic [4:0]      o_rsb,
    output logic [4:0]      o_rd,
    output logic            o_alu_pc,
    output logic            o_alu_imm,
    output logic            o_alu_en,
    output logic            o_ma_wr,
    output logic            o_ma_rd,
    output logic            o_wb_en,
    output logic            o_system,
    output logic [1:0]      o_wb_mux,
    output logic            o_illegal,
`ifdef DECODE_STAGE_RV32M_EN
    output logic            o_mdu,
`endif
    output logic            o_sb_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [4:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [REG_W-1:0] rsa;
        logic [REG_W-1:0] rsb;
        logic [REG_W-1:0] rd;
        logic             alu_pc;
        logic             alu_imm;
        logic             alu_en;
        logic             ma_wr;
        logic             ma_rd;
        logic             wb_en;
        logic             system;
        logic [1:0]       wb_mux;
        logic             illegal;
`ifdef DECODE_STAGE_RV32M_EN
        logic             mdu;
`endif
        logic             use_rsa;
        logic             use_rsb;
    } bundle_t;

    logic [4:0] opc;
    logic [6:0] f7;
    logic       is_load, is_op_imm, is_auipc, is_store, is_op;
    logic       is_lui, is_branch, is_jalr, is_jal, is_system;
    logic       legal_opc, f7_ok, illegal;
    logic [XLEN-1:0] imm;
    bundle_t    dec_bundle;

    bundle_t    bundle_q, bundle_d;
    logic       q_valid_q, q_valid_d;
    logic       sb_err_q, sb_err_d;
    logic [NREGS-1:0][PEND_W-1:0] pend_q, pend_d;

    logic       hazard, valid_c, ready_c, issue, load;
    logic       inc_hit, dec_hit;

    assign opc       = i_instr[6:2];
    assign f7        = i_instr[31:25];
    assign is_load   = (opc == OPC_LOAD);
    assign is_op_imm = (opc == OPC_OP_IMM);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_store  = (opc == OPC_STORE);
    assign is_op     = (opc == OPC_OP);
    assign is_lui    = (opc == OPC_LUI);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_jal    = (opc == OPC_JAL);
    assign is_system = (opc == OPC_SYSTEM);
    assign legal_opc = is_load | is_op_imm | is_auipc | is_store | is_op
                     | is_lui | is_branch | is_jalr | is_jal | is_system;

`ifdef DECODE_STAGE_RV32M_EN
    logic mdu_word;
    assign mdu_word = is_op && (f7 == 7'b0000001) && (i_instr[1:0] == 2'b11);
    assign f7_ok    = (f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001);
`else
    assign f7_ok    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
`endif

    assign illegal = (i_instr[1:0] != 2'b11) || !legal_opc || (is_op && !f7_ok);

    // Immediate selected by instruction format; R-type and unknown opcodes give 0
    always_comb begin
        imm = '0;
        if (is_lui || is_auipc) begin
            imm = {i_instr[31:12], 12'b0};
        end else if (is_jal) begin
            imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        end else if (is_branch) begin
            imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        end else if (is_store) begin
            imm = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
        end else if (is_load || is_op_imm || is_jalr || is_system) begin
            imm = {{21{i_instr[31]}}, i_instr[30:20]};
        end
    end

    // Full decode of the incoming word into a candidate bundle
    always_comb begin
        dec_bundle         = '0;
        dec_bundle.pc      = i_pc;
        dec_bundle.imm     = imm;
        dec_bundle.opcode  = opc;
        dec_bundle.funct3  = i_instr[14:12];
        dec_bundle.funct7  = f7;
        dec_bundle.rsa     = is_lui ? '0 : i_instr[19:15];
        dec_bundle.rsb     = i_instr[24:20];
        dec_bundle.rd      = i_instr[11:7];
        dec_bundle.alu_pc  = is_jal || is_auipc || is_branch;
        dec_bundle.alu_imm = !is_op;
        dec_bundle.alu_en  = is_op || is_op_imm;
        dec_bundle.ma_wr   = is_store && !illegal;
        dec_bundle.ma_rd   = is_load && !illegal;
        dec_bundle.wb_en   = !(is_store || is_branch) && !illegal;
        dec_bundle.system  = is_system;
        dec_bundle.wb_mux  = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
        dec_bundle.illegal = illegal;
`ifdef DECODE_STAGE_RV32M_EN
        dec_bundle.mdu     = mdu_word;
`endif
        dec_bundle.use_rsa = !(is_lui || is_auipc || is_jal);
        dec_bundle.use_rsb = is_branch || is_store || is_op;
    end

    // Hazard check on registered counters only, so a writeback releases a source one cycle later
    assign hazard = (bundle_q.use_rsa && (bundle_q.rsa != '0) && (pend_q[bundle_q.rsa] != '0))
                 || (bundle_q.use_rsb && (bundle_q.rsb != '0) && (pend_q[bundle_q.rsb] != '0))
                 || (bundle_q.wb_en && (bundle_q.rd != '0) && (pend_q[bundle_q.rd] == PEND_MAX));

    assign valid_c = q_valid_q && !hazard && !i_flush;
    assign ready_c = !i_flush && (!q_valid_q || (valid_c && i_ready));
    assign issue   = valid_c && i_ready;
    assign load    = i_valid && ready_c;

    // Next-state: bundle capture, occupancy, and scoreboard counters
    always_comb begin
        bundle_d  = bundle_q;
        q_valid_d = q_valid_q;
        pend_d    = pend_q;
        sb_err_d  = sb_err_q;
        inc_hit   = 1'b0;
        dec_hit   = 1'b0;
        if (load) begin
            bundle_d = dec_bundle;
        end
        if (i_flush) begin
            q_valid_d = 1'b0;
        end else if (load) begin
            q_valid_d = 1'b1;
        end else if (issue) begin
            q_valid_d = 1'b0;
        end
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc_hit = issue && bundle_q.wb_en && (bundle_q.rd == REG_W'(r));
            dec_hit = i_wb_valid && (i_wb_rd == REG_W'(r));
            if (inc_hit && !dec_hit) begin
                pend_d[r] = pend_q[r] + PEND_W'(1);
            end else if (dec_hit && !inc_hit) begin
                if (pend_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - PEND_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bundle_q  <= '0;
            q_valid_q <= 1'b0;
            pend_q    <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            bundle_q  <= bundle_d;
            q_valid_q <= q_valid_d;
            pend_q    <= pend_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign o_valid     = valid_c;
    assign o_ready     = ready_c;
    assign o_pc        = bundle_q.pc;
    assign o_immediate = bundle_q.imm;
    assign o_opcode    = bundle_q.opcode;
    assign o_funct3    = bundle_q.funct3;
    assign o_funct7    = bundle_q.funct7;
    assign o_rsa       = bundle_q.rsa;
    assign o_rsb       = bundle_q.rsb;
    assign o_rd        = bundle_q.rd;
    assign o_alu_pc    = bundle_q.alu_pc;
    assign o_alu_imm   = bundle_q.alu_imm;
    assign o_alu_en    = bundle_q.alu_en;
    assign o_ma_wr     = bundle_q.ma_wr;
    assign o_ma_rd     = bundle_q.ma_rd;
    assign o_wb_en     = bundle_q.wb_en;
    assign o_system    = bundle_q.system;
    assign o_wb_mux    = bundle_q.wb_mux;
    assign o_illegal   = bundle_q.illegal;
`ifdef DECODE_STAGE_RV32M_EN
    assign o_mdu       = bundle_q.mdu;
`endif
    assign o_sb_err    = sb_err_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic against a behavioural model of decode_stage.
module tb_decode_stage;

    localparam int MAXP = 3;
`ifdef DECODE_STAGE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [4:0] K_LOAD = 5'h00, K_OPIMM = 5'h04, K_AUIPC = 5'h05, K_STORE = 5'h08,
                           K_OP = 5'h0C, K_LUI = 5'h0D, K_BRANCH = 5'h18, K_JALR = 5'h19,
                           K_JAL = 5'h1B, K_SYS = 5'h1C;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rsa, rsb, rd;
        logic alu_pc, alu_imm, alu_en, ma_wr, ma_rd, wb_en, system;
        logic [1:0]  wb_mux;
        logic illegal, mdu;
    } exp_t;

    logic clk = 1'b0;
    logic i_rst_n, i_valid, i_flush, i_wb_valid, i_ready;
    logic [31:0] i_instr, i_pc;
    logic [4:0]  i_wb_rd;
    logic o_ready, o_valid;
    logic [31:0] o_pc, o_immediate;
    logic [4:0]  o_opcode, o_rsa, o_rsb, o_rd;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic o_alu_pc, o_alu_imm, o_alu_en, o_ma_wr, o_ma_rd, o_wb_en, o_system, o_illegal, o_sb_err;
    logic [1:0]  o_wb_mux;
    logic o_mdu_w;

    int vecs = 0;
    int errs = 0;

    bit          m_qv = 1'b0;
    logic [31:0] m_w  = '0;
    logic [31:0] m_pc = '0;
    int          m_pend [32];
    bit          m_err = 1'b0;
    int          inflight [$];

    always #5 clk = ~clk;

    decode_stage dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_wb_valid(i_wb_valid),
        .i_wb_rd(i_wb_rd), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
        .o_immediate(o_immediate), .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_rsa(o_rsa), .o_rsb(o_rsb), .o_rd(o_rd), .o_alu_pc(o_alu_pc), .o_alu_imm(o_alu_imm),
        .o_alu_en(o_alu_en), .o_ma_wr(o_ma_wr), .o_ma_rd(o_ma_rd), .o_wb_en(o_wb_en),
        .o_system(o_system), .o_wb_mux(o_wb_mux), .o_illegal(o_illegal),
`ifdef DECODE_STAGE_RV32M_EN
        .o_mdu(o_mdu_w),
`endif
        .o_sb_err(o_sb_err)
    );
`ifndef DECODE_STAGE_RV32M_EN
    assign o_mdu_w = 1'b0;
`endif

    // Reference decode from the ISA rules, immediates built arithmetically
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int s;
        logic [4:0] k;
        bit legal;
        e = '0;
        s = 0;
        k = w[6:2];
        legal = (w[1:0] == 2'b11) &&
                (k inside {K_LOAD, K_OPIMM, K_AUIPC, K_STORE, K_OP, K_LUI, K_BRANCH, K_JALR, K_JAL, K_SYS});
        if (k == K_OP)
            legal = legal && (w[31:25] == 7'h00 || w[31:25] == 7'h20 || (M_EN && w[31:25] == 7'h01));
        e.pc = pc; e.opcode = k; e.f3 = w[14:12]; e.f7 = w[31:25];
        e.rsa = (k == K_LUI) ? 5'd0 : w[19:15];
        e.rsb = w[24:20]; e.rd = w[11:7];
        case (k)
            K_LUI, K_AUIPC: s = int'(w & 32'hFFFF_F000);
            K_LOAD, K_OPIMM, K_JALR, K_SYS: s = (w[31] ? -2048 : 0) + int'(w[30:20]);
            K_STORE:  s = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
            K_BRANCH: s = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            K_JAL:    s = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default:  s = 0;
        endcase
        e.imm     = 32'(s);
        e.alu_pc  = k inside {K_JAL, K_AUIPC, K_BRANCH};
        e.alu_imm = (k != K_OP);
        e.alu_en  = (k == K_OP) || (k == K_OPIMM);
        e.ma_wr   = legal && (k == K_STORE);
        e.ma_rd   = legal && (k == K_LOAD);
        e.wb_en   = legal && !(k == K_STORE || k == K_BRANCH);
        e.system  = (k == K_SYS);
        e.wb_mux  = (k == K_LOAD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        e.illegal = !legal;
        e.mdu     = M_EN && (k == K_OP) && (w[31:25] == 7'h01) && (w[1:0] == 2'b11);
        return e;
    endfunction

    function automatic bit uses_a(input logic [31:0] w);
        return !(w[6:2] inside {K_LUI, K_AUIPC, K_JAL});
    endfunction

    function automatic bit uses_b(input logic [31:0] w);
        return w[6:2] inside {K_BRANCH, K_STORE, K_OP};
    endfunction

    function automatic bit m_hazard();
        exp_t e = ref_dec(m_w, m_pc);
        return (uses_a(m_w) && e.rsa != 0 && m_pend[e.rsa] != 0)
            || (uses_b(m_w) && e.rsb != 0 && m_pend[e.rsb] != 0)
            || (e.wb_en && e.rd != 0 && m_pend[e.rd] == MAXP);
    endfunction

    function automatic bit m_valid();
        return m_qv && !m_hazard() && !i_flush;
    endfunction

    function automatic bit m_ready();
        return !i_flush && (!m_qv || (m_valid() && i_ready));
    endfunction

    function automatic exp_t act_bundle();
        return {o_pc, o_immediate, o_opcode, o_funct3, o_funct7, o_rsa, o_rsb, o_rd, o_alu_pc,
                o_alu_imm, o_alu_en, o_ma_wr, o_ma_rd, o_wb_en, o_system, o_wb_mux, o_illegal, o_mdu_w};
    endfunction

    // One clock: model next state from current inputs, advance, settle
    task automatic cycle();
        exp_t e;
        bit issue, load, rst_n;
        int inc_r, dec_r;
        logic [31:0] w, pc;
        e = ref_dec(m_w, m_pc);
        issue = m_valid() && i_ready;
        load  = i_valid && m_ready();
        inc_r = (issue && e.wb_en && e.rd != 0) ? int'(e.rd) : 0;
        dec_r = (i_wb_valid && i_wb_rd != 0) ? int'(i_wb_rd) : 0;
        rst_n = i_rst_n; w = i_instr; pc = i_pc;
        @(posedge clk);
        if (!rst_n) begin
            m_qv = 0; m_err = 0; inflight.delete();
            foreach (m_pend[r]) m_pend[r] = 0;
        end else begin
            if (inc_r != 0) inflight.push_back(inc_r);
            if (!(inc_r != 0 && inc_r == dec_r)) begin
                if (inc_r != 0) m_pend[inc_r]++;
                if (dec_r != 0) begin
                    if (m_pend[dec_r] == 0) m_err = 1; else m_pend[dec_r]--;
                end
            end
            if (i_flush) m_qv = 0;
            else if (load) m_qv = 1;
            else if (issue) m_qv = 0;
            if (load) begin m_w = w; m_pc = pc; end
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_valid = 0; i_flush = 0; i_ready = 0; i_wb_valid = 0; i_wb_rd = 0;
        i_instr = 0; i_pc = 0;
        cycle(); cycle();
        i_rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        vecs++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        vecs++; if (o_sb_err !== 1'b0) begin errs++; $display("FAIL reset_sb_err: got %b want 0", o_sb_err); end
        vecs++; if (act_bundle() !== '0) begin errs++; $display("FAIL reset_bundle: got %h want 0", act_bundle()); end
    endtask

    task automatic test_addi_raw();
        do_reset();
        i_valid = 1; i_instr = 32'h0050_0093; i_pc = 32'h100; i_ready = 0;
        cycle();
        i_valid = 0; #1;
        vecs++; if (o_valid !== 1'b1) begin errs++; $display("FAIL addi_valid: got %b want 1", o_valid); end
        vecs++; if ({o_rd, o_immediate} !== {5'd1, 32'd5}) begin errs++; $display("FAIL addi_rd_imm: got %h want %h", {o_rd, o_immediate}, {5'd1, 32'd5}); end
        vecs++; if ({o_alu_imm, o_alu_en, o_wb_en, o_illegal} !== 4'b1110) begin errs++; $display("FAIL addi_flags: got %b want 1110", {o_alu_imm, o_alu_en, o_wb_en, o_illegal}); end
        i_ready = 1; cycle();
        i_valid = 1; i_instr = 32'h0010_8133; i_pc = 32'h104; cycle();
        i_valid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL raw_stall c%0d: got %b want 0", c, o_valid); end
            cycle();
        end
        i_wb_valid = 1; i_wb_rd = 5'd1; #1;
        vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL raw_no_bypass: got %b want 0", o_valid); end
        cycle();
        i_wb_valid = 0; #1;
        vecs++; if (o_valid !== 1'b1 || o_pc !== 32'h104) begin errs++; $display("FAIL raw_release: got v=%b pc=%h want v=1 pc=104", o_valid, o_pc); end
        cycle();
    endtask

    task automatic test_back_to_back();
        int issues;
        do_reset();
        i_valid = 1; i_instr = 32'h0000_10B7; i_pc = 32'h200; i_ready = 0; cycle();
        i_instr = 32'h0000_2137; i_pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if ({o_valid, o_ready} !== 2'b10) begin errs++; $display("FAIL hold_hs c%0d: got %b want 10", c, {o_valid, o_ready}); end
            vecs++; if ({o_pc, o_immediate, o_rd} !== {32'h200, 32'h1000, 5'd1}) begin errs++; $display("FAIL hold_stable c%0d: got %h", c, {o_pc, o_immediate, o_rd}); end
            cycle();
        end
        do_reset();
        issues = 0; i_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1; i_instr = (32'(k) << 12) | (32'(k) << 7) | 32'h37; i_pc = 32'h300 + 32'(4 * k);
            #1;
            if (k > 1) begin
                vecs++; if ({o_valid, o_ready} !== 2'b11 || o_pc !== 32'h300 + 32'(4 * (k - 1))) begin errs++; $display("FAIL stream k%0d: got v/r=%b pc=%h", k, {o_valid, o_ready}, o_pc); end
            end
            if (o_valid && i_ready) issues++;
            cycle();
        end
        i_valid = 0; #1;
        if (o_valid && i_ready) issues++;
        cycle();
        vecs++; if (issues != 8) begin errs++; $display("FAIL stream_count: got %0d want 8", issues); end
    endtask

    task automatic test_pend_max();
        do_reset();
        i_ready = 1; i_valid = 1; i_instr = 32'h0010_0293; i_pc = 32'h400;
        for (int k = 0; k < 4; k++) cycle();
        i_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            vecs++; if ({o_valid, o_ready} !== 2'b00) begin errs++; $display("FAIL pend_max_stall c%0d: got %b want 00", c, {o_valid, o_ready}); end
            cycle();
        end
        i_wb_valid = 1; i_wb_rd = 5'd5; #1;
        vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL pend_max_wb_cycle: got %b want 0", o_valid); end
        cycle();
        i_wb_valid = 0; #1;
        vecs++; if (o_valid !== 1'b1) begin errs++; $display("FAIL pend_max_release: got %b want 1", o_valid); end
        vecs++; if (o_sb_err !== 1'b0) begin errs++; $display("FAIL sb_err_early: got %b want 0", o_sb_err); end
        cycle();
        i_wb_valid = 1; i_wb_rd = 5'd6; cycle();
        i_wb_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            vecs++; if (o_sb_err !== 1'b1) begin errs++; $display("FAIL sb_err_sticky c%0d: got %b want 1", c, o_sb_err); end
            cycle();
        end
    endtask

    task automatic test_flush_illegal();
        do_reset();
        i_ready = 1; i_valid = 1; i_instr = 32'h0050_0093; i_pc = 32'h500; cycle();
        i_instr = 32'h0010_8133; i_pc = 32'h504; cycle();
        i_valid = 1; i_flush = 1; i_instr = 32'h0000_0013; #1;
        vecs++; if ({o_valid, o_ready} !== 2'b00) begin errs++; $display("FAIL flush_cycle: got %b want 00", {o_valid, o_ready}); end
        cycle();
        i_flush = 0; i_valid = 0; #1;
        vecs++; if ({o_valid, o_ready} !== 2'b01) begin errs++; $display("FAIL flush_after: got %b want 01", {o_valid, o_ready}); end
        i_valid = 1; i_instr = 32'h0010_8133; i_pc = 32'h508; cycle();
        i_valid = 0; #1;
        vecs++; if (o_valid !== 1'b0) begin errs++; $display("FAIL flush_keeps_pend: got %b want 0", o_valid); end
        i_wb_valid = 1; i_wb_rd = 5'd1; cycle();
        i_wb_valid = 0; #1;
        vecs++; if (o_valid !== 1'b1) begin errs++; $display("FAIL flush_release: got %b want 1", o_valid); end
        cycle();
        i_valid = 1; i_instr = 32'h0; i_pc = 32'h50C; cycle();
        i_valid = 0; #1;
        vecs++; if ({o_valid, o_illegal, o_wb_en, o_ma_rd} !== 4'b1100) begin errs++; $display("FAIL illegal_zero: got %b want 1100", {o_valid, o_illegal, o_wb_en, o_ma_rd}); end
        cycle();
    endtask

    task automatic test_mul();
        exp_t e;
        do_reset();
        i_ready = 0; i_valid = 1; i_instr = 32'h0220_8033; i_pc = 32'h600; cycle();
        i_valid = 0; #1;
        e = ref_dec(32'h0220_8033, 32'h600);
        vecs++; if ({o_valid, o_illegal, o_mdu_w, o_wb_en} !== {1'b1, !M_EN, M_EN, M_EN}) begin errs++; $display("FAIL mul_decode: got %b want %b", {o_valid, o_illegal, o_mdu_w, o_wb_en}, {1'b1, !M_EN, M_EN, M_EN}); end
        vecs++; if (act_bundle() !== e) begin errs++; $display("FAIL mul_bundle: got %h want %h", act_bundle(), e); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0] k;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        case ($urandom_range(0, 9))
            0: k = K_LOAD;  1: k = K_OPIMM;  2: k = K_AUIPC; 3: k = K_STORE; 4: k = K_OP;
            5: k = K_LUI;   6: k = K_BRANCH; 7: k = K_JALR;  8: k = K_JAL;   default: k = K_SYS;
        endcase
        w[6:2] = k; w[1:0] = 2'b11;
        w[11:7] = 5'($urandom_range(0, 7)); w[19:15] = 5'($urandom_range(0, 7)); w[24:20] = 5'($urandom_range(0, 7));
        if (k == K_OP) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 24) == 0);
            i_instr = rand_instr();
            i_pc = $urandom & ~32'h3;
            i_wb_valid = 0; i_wb_rd = 0;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                int idx = $urandom_range(0, inflight.size() - 1);
                i_wb_valid = 1; i_wb_rd = 5'(inflight[idx]); inflight.delete(idx);
            end
            #1;
            vecs++; if ({o_valid, o_ready, o_sb_err} !== {m_valid(), m_ready(), m_err}) begin errs++; $display("FAIL rnd_hs n%0d: got %b want %b", n, {o_valid, o_ready, o_sb_err}, {m_valid(), m_ready(), m_err}); end
            if (m_qv) begin
                vecs++; if (act_bundle() !== ref_dec(m_w, m_pc)) begin errs++; $display("FAIL rnd_bundle n%0d w=%h: got %h want %h", n, m_w, act_bundle(), ref_dec(m_w, m_pc)); end
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_addi_raw();
        test_back_to_back();
        test_pend_max();
        test_flush_illegal();
        test_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
